// File: rtl/mult_pkg.sv
// mult_pkg: shared widths, operand/product types, S1 register layout and Booth digit helper.
package mult_pkg;
    localparam int MULT_W   = 16;
    localparam int PROD_W   = 32;
    localparam int ID_MAX_W = 3;

    typedef logic signed [MULT_W-1:0] operand_t;
    typedef logic signed [PROD_W-1:0] product_t;

    typedef struct packed {
        operand_t            x;
        operand_t            y;
        logic [ID_MAX_W-1:0] id;
    } s1_t;

    // Radix-4 Booth partial product for one recoded digit group {b[2i+1], b[2i], b[2i-1]}
    function automatic logic signed [MULT_W+1:0] booth_pp(input operand_t a, input logic [2:0] g);
        logic signed [MULT_W+1:0] m;
        m = (g[1] ^ g[0]) ? {{2{a[MULT_W-1]}}, a} :
            (g == 3'b011 || g == 3'b100) ? {a[MULT_W-1], a, 1'b0} : '0;
        return g[2] ? -m : m;
    endfunction
endpackage

// File: rtl/mult_share_arbiter_if.sv
// mult_share_arbiter_if: per-requester request handshakes and the shared tagged result port.
interface mult_share_arbiter_if
    import mult_pkg::*;
#(
    parameter int N_REQ = 4,
    parameter int ID_W  = (N_REQ > 1) ? $clog2(N_REQ) : 1
);
    logic [N_REQ-1:0]        req_valid;
    logic [N_REQ-1:0]        req_ready;
    logic [MULT_W*N_REQ-1:0] req_x;
    logic [MULT_W*N_REQ-1:0] req_y;
    logic                    res_valid;
    logic                    res_ready;
    logic [PROD_W-1:0]       res_data;
    logic [ID_W-1:0]         res_id;

    modport master (
        output req_valid, req_x, req_y, res_ready,
        input  req_ready, res_valid, res_data, res_id
    );

    modport slave (
        input  req_valid, req_x, req_y, res_ready,
        output req_ready, res_valid, res_data, res_id
    );
endinterface

// File: rtl/booth_mul.sv
// booth_mul: combinational signed 16x16 radix-4 Booth multiplier with adder-tree reduction.
module booth_mul
    import mult_pkg::*;
(
    input  operand_t a,
    input  operand_t b,
    output product_t p
);
    logic [MULT_W:0] be;

    assign be = {b, 1'b0};

    always_comb begin
        p = '0;
        for (int i = 0; i < MULT_W / 2; i++)
            p = p + (product_t'(booth_pp(a, be[2*i +: 3])) << (2 * i));
    end
endmodule

// File: rtl/rr_arbiter.sv
// rr_arbiter: one-hot round-robin grant searching upward from ptr, with encoded winner.
module rr_arbiter #(
    parameter int N  = 4,
    parameter int IW = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]  req,
    input  logic [IW-1:0] ptr,
    input  logic          en,
    output logic [N-1:0]  gnt,
    output logic [IW-1:0] id
);
    int j;

    // Scan from farthest to nearest offset so the nearest pending request wins
    always_comb begin
        gnt = '0;
        id  = '0;
        j   = 0;
        for (int k = N - 1; k >= 0; k--) begin
            j = (int'(ptr) + k) % N;
            if (en && req[j]) begin
                gnt = N'(1) << j;
                id  = IW'(j);
            end
        end
    end
endmodule

// File: rtl/mult_share_arbiter.sv
// mult_share_arbiter: round-robin sharing of one signed multiplier across N_REQ requesters
// through an operand stage (S1) and a result stage (S2) with full backpressure.
module mult_share_arbiter
    import mult_pkg::*;
#(
    parameter int N_REQ = 4,
    parameter int ID_W  = (N_REQ > 1) ? $clog2(N_REQ) : 1
) (
    input  logic                 clk,
    input  logic                 rst_n,
    mult_share_arbiter_if.slave  bus,
    output logic                 busy
);
    logic              s1_valid;
    s1_t               s1;
    logic [ID_W-1:0]   rr_ptr;
    logic [ID_W-1:0]   win_id;
    logic [N_REQ-1:0]  gnt;
    logic              any_gnt;
    logic              s1_en;
    logic              s2_en;
    product_t          prod;

    assign s2_en   = !bus.res_valid || bus.res_ready;
    assign s1_en   = !s1_valid || s2_en;
    assign any_gnt = |gnt;
    assign busy    = s1_valid || bus.res_valid;
    assign bus.req_ready = gnt;

    // rst_n gates the enable so no grant is visible while reset is held
    rr_arbiter #(.N(N_REQ), .IW(ID_W)) u_arb (
        .req (bus.req_valid),
        .ptr (rr_ptr),
        .en  (s1_en && rst_n),
        .gnt (gnt),
        .id  (win_id)
    );

    booth_mul u_mul (
        .a (s1.x),
        .b (s1.y),
        .p (prod)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid      <= 1'b0;
            s1            <= '0;
            rr_ptr        <= '0;
            bus.res_valid <= 1'b0;
            bus.res_data  <= '0;
            bus.res_id    <= '0;
        end else begin
            if (s1_en)
                s1_valid <= any_gnt;
            if (any_gnt) begin
                s1     <= '{x:  bus.req_x[MULT_W*int'(win_id) +: MULT_W],
                            y:  bus.req_y[MULT_W*int'(win_id) +: MULT_W],
                            id: ID_MAX_W'(win_id)};
                rr_ptr <= (win_id == ID_W'(N_REQ - 1)) ? '0 : win_id + 1'b1;
            end
            if (s2_en) begin
                bus.res_valid <= s1_valid;
                bus.res_data  <= prod;
                bus.res_id    <= s1.id[ID_W-1:0];
            end
        end
    end
endmodule
